sya_skew_feeder: RTL and testbench

//  Transmit side of the systolic PE bank input interface. Joins one act vector (NUM_ROW lanes) and one wgt vector
//  (NUM_COL lanes) per beat over valid/ready. Skews them: act row r delayed r steps, wgt col c delayed c steps.

---
 rtl/sya_skew_feeder_if.sv | 25 ++
 rtl/sya_skew_feeder.sv | 164 ++++++++++++++++
 tb/tb_sya_skew_feeder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sya_skew_feeder_if.sv
// Upstream act/wgt vector streams into the systolic skew feeder.
// master = vector producer, slave = feeder.
interface sya_skew_feeder_if #(
  parameter int unsigned NUM_ROW   = 16,
  parameter int unsigned NUM_COL   = 16,
  parameter int unsigned ACT_WIDTH = 8,
  parameter int unsigned WGT_WIDTH = 8
);
  logic                           act_vld;
  logic                           act_rdy;
  logic [ACT_WIDTH*NUM_ROW-1:0]   act_data;
  logic                           wgt_vld;
  logic                           wgt_rdy;
  logic [WGT_WIDTH*NUM_COL-1:0]   wgt_data;

  modport master (
    output act_vld, act_data, wgt_vld, wgt_data,
    input  act_rdy, wgt_rdy
  );

  modport slave (
    input  act_vld, act_data, wgt_vld, wgt_data,
    output act_rdy, wgt_rdy
  );
endinterface

// File: rtl/sya_skew_feeder.sv
// Joins act/wgt vectors, skews row r / col c by r / c advances and drives the
// left/above edge of a systolic PE bank for one tile of cfg_k beats plus a flush.
module sya_skew_feeder #(
  parameter int unsigned NUM_ROW   = 16,
  parameter int unsigned NUM_COL   = 16,
  parameter int unsigned ACT_WIDTH = 8,
  parameter int unsigned WGT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         cfg_k,
  output logic                         busy,
  output logic                         done,
  sya_skew_feeder_if.slave             src,
  input  logic                         bank_stall,
  output logic                         out_vld_left,
  output logic                         out_rdy_left,
  output logic [ACT_WIDTH*NUM_ROW-1:0] out_act_left,
  output logic [WGT_WIDTH*NUM_COL-1:0] out_wgt_above,
  output logic                         out_acc_reset
);

  localparam int unsigned MAX_LANE = (NUM_ROW > NUM_COL) ? NUM_ROW : NUM_COL;
  localparam int unsigned DRAIN_W  = (MAX_LANE > 2) ? $clog2(MAX_LANE - 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [CNT_WIDTH-1:0]         k_q;
  logic [CNT_WIDTH-1:0]         beat_cnt;
  logic [DRAIN_W-1:0]           drain_cnt;
  logic                         accept;
  logic                         advance;
  logic                         done_set;
  logic                         last_beat;
  logic                         drain_last;
  logic [ACT_WIDTH*NUM_ROW-1:0] act_in;
  logic [WGT_WIDTH*NUM_COL-1:0] wgt_in;

  assign last_beat  = (beat_cnt == (k_q - CNT_WIDTH'(1)));
  assign drain_last = (drain_cnt == DRAIN_W'(MAX_LANE - 2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && (cfg_k != '0)) begin
          state_nxt = FEED;
        end
      end
      FEED: begin
        if (accept && last_beat) begin
          state_nxt = (MAX_LANE > 1) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (advance && drain_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake, advance enable and lane inputs
  always_comb begin
    accept   = 1'b0;
    advance  = 1'b0;
    done_set = 1'b0;
    act_in   = '0;
    wgt_in   = '0;
    if (state == FEED) begin
      accept = src.act_vld & src.wgt_vld & ~bank_stall;
    end
    advance  = accept | ((state == DRAIN) & ~bank_stall);
    done_set = ((state == IDLE) & start & (cfg_k == '0)) |
               ((state != IDLE) & (state_nxt == IDLE));
    if (accept) begin
      act_in = src.act_data;
      wgt_in = src.wgt_data;
    end
  end

  assign src.act_rdy   = accept;
  assign src.wgt_rdy   = accept;
  assign out_vld_left  = accept;
  assign out_rdy_left  = advance;
  assign out_acc_reset = accept & (beat_cnt == '0);

  // Tile bookkeeping and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= done_set;
      if ((state == IDLE) && start && (cfg_k != '0)) begin
        k_q      <= cfg_k;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
      if (state == FEED) begin
        drain_cnt <= '0;
      end else if ((state == DRAIN) && advance) begin
        drain_cnt <= drain_cnt + DRAIN_W'(1);
      end
    end
  end

  // Lane 0 bypasses the delay lines
  assign out_act_left[ACT_WIDTH-1:0]  = act_in[ACT_WIDTH-1:0];
  assign out_wgt_above[WGT_WIDTH-1:0] = wgt_in[WGT_WIDTH-1:0];

  // Row r: r-deep delay line, shifting only when the bank advances
  for (genvar r = 1; r < NUM_ROW; r++) begin : g_act
    logic [ACT_WIDTH-1:0] sr [r];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < r; i++) sr[i] <= '0;
      end else if (advance) begin
        sr[0] <= act_in[r*ACT_WIDTH +: ACT_WIDTH];
        for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
      end
    end
    assign out_act_left[r*ACT_WIDTH +: ACT_WIDTH] = sr[r-1];
  end

  // Col c: c-deep delay line, shifting only when the bank advances
  for (genvar c = 1; c < NUM_COL; c++) begin : g_wgt
    logic [WGT_WIDTH-1:0] sr [c];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < c; i++) sr[i] <= '0;
      end else if (advance) begin
        sr[0] <= wgt_in[c*WGT_WIDTH +: WGT_WIDTH];
        for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
      end
    end
    assign out_wgt_above[c*WGT_WIDTH +: WGT_WIDTH] = sr[c-1];
  end

endmodule

// File: tb/tb_sya_skew_feeder.sv
// Bench for sya_skew_feeder: a 4x4 and a 16x16 instance share stimulus; a
// beat scoreboard predicts every skewed edge vector, handshake and done pulse.
module tb_sya_skew_feeder;
  localparam int unsigned AW = 8;
  localparam int unsigned WW = 8;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel, start, bank_stall, act_vld, wgt_vld;
  logic [CW-1:0] cfg_k;
  logic [127:0]  act_data, wgt_data;

  logic        busy4, done4, vld4, rdy4, ar4;
  logic [31:0] act4, wgt4;
  logic        busy16, done16, vld16, rdy16, ar16;
  logic [127:0] act16, wgt16;

  sya_skew_feeder_if #(.NUM_ROW(4), .NUM_COL(4), .ACT_WIDTH(AW), .WGT_WIDTH(WW)) if4 ();
  sya_skew_feeder_if #(.NUM_ROW(16), .NUM_COL(16), .ACT_WIDTH(AW), .WGT_WIDTH(WW)) if16 ();

  assign if4.act_vld   = act_vld;
  assign if4.wgt_vld   = wgt_vld;
  assign if4.act_data  = act_data[31:0];
  assign if4.wgt_data  = wgt_data[31:0];
  assign if16.act_vld  = act_vld;
  assign if16.wgt_vld  = wgt_vld;
  assign if16.act_data = act_data;
  assign if16.wgt_data = wgt_data;

  sya_skew_feeder #(.NUM_ROW(4), .NUM_COL(4), .ACT_WIDTH(AW), .WGT_WIDTH(WW), .CNT_WIDTH(CW)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .cfg_k(cfg_k), .busy(busy4), .done(done4),
    .src(if4.slave), .bank_stall(bank_stall), .out_vld_left(vld4), .out_rdy_left(rdy4),
    .out_act_left(act4), .out_wgt_above(wgt4), .out_acc_reset(ar4)
  );

  sya_skew_feeder #(.NUM_ROW(16), .NUM_COL(16), .ACT_WIDTH(AW), .WGT_WIDTH(WW), .CNT_WIDTH(CW)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .cfg_k(cfg_k), .busy(busy16), .done(done16),
    .src(if16.slave), .bank_stall(bank_stall), .out_vld_left(vld16), .out_rdy_left(rdy16),
    .out_act_left(act16), .out_wgt_above(wgt16), .out_acc_reset(ar16)
  );

  // Selected DUT's observable outputs
  logic         o_busy, o_done, o_vld, o_rdy, o_ar, o_act_rdy, o_wgt_rdy;
  logic [127:0] o_act, o_wgt;
  always_comb begin
    o_busy    = sel ? busy16 : busy4;
    o_done    = sel ? done16 : done4;
    o_vld     = sel ? vld16 : vld4;
    o_rdy     = sel ? rdy16 : rdy4;
    o_ar      = sel ? ar16 : ar4;
    o_act_rdy = sel ? if16.act_rdy : if4.act_rdy;
    o_wgt_rdy = sel ? if16.wgt_rdy : if4.wgt_rdy;
    o_act     = sel ? act16 : {96'b0, act4};
    o_wgt     = sel ? wgt16 : {96'b0, wgt4};
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: accepted beats queued, popped once the deepest lane has emitted them
  logic [127:0] act_q[$];
  logic [127:0] wgt_q[$];
  int m_k, m_acc, m_j, m_drn, sb_base, dut_adv, dut_ar;
  bit m_active, done_pend, mon_en;

  function automatic int lanes();
    return sel ? 16 : 4;
  endfunction

  task automatic model_clear();
    act_q.delete();
    wgt_q.delete();
    m_k = 0; m_acc = 0; m_j = 0; m_drn = 0; sb_base = 0; dut_adv = 0; dut_ar = 0;
    m_active = 1'b0;
    done_pend = 1'b0;
  endtask

  function automatic logic [127:0] exp_vec(input int j, input bit is_act);
    logic [127:0] v, beat;
    int b;
    v = '0;
    for (int r = 0; r < lanes(); r++) begin
      b = j - r;
      if (b >= sb_base && b < m_acc) begin
        beat = is_act ? act_q[b - sb_base] : wgt_q[b - sb_base];
        v[r*8 +: 8] = beat[r*8 +: 8];
      end
    end
    return v;
  endfunction

  task automatic monitor_step();
    bit exp_done, exp_acc, exp_adv;
    logic [127:0] tmp;
    int nr;
    nr = lanes();
    exp_done = done_pend;
    done_pend = 1'b0;
    exp_acc = m_active && (m_acc < m_k) && act_vld && wgt_vld && !bank_stall;
    exp_adv = exp_acc || (m_active && (m_acc == m_k) && !bank_stall);
    check("done", 128'(o_done), 128'(exp_done));
    check("busy", 128'(o_busy), 128'(m_active));
    check("act_rdy", 128'(o_act_rdy), 128'(exp_acc));
    check("wgt_rdy", 128'(o_wgt_rdy), 128'(exp_acc));
    check("out_vld", 128'(o_vld), 128'(exp_acc));
    check("advance", 128'(o_rdy), 128'(exp_adv));
    check("acc_reset", 128'(o_ar), 128'(exp_acc && (m_acc == 0)));
    if (o_rdy) dut_adv++;
    if (o_ar) dut_ar++;
    if (exp_acc) begin
      act_q.push_back(act_data);
      wgt_q.push_back(wgt_data);
      m_acc++;
    end
    if (exp_adv) begin
      check("act_lanes", o_act, exp_vec(m_j, 1'b1));
      check("wgt_lanes", o_wgt, exp_vec(m_j, 1'b0));
      if ((m_j == sb_base + nr - 1) && (act_q.size() > 0)) begin
        tmp = act_q.pop_front();
        tmp = wgt_q.pop_front();
        sb_base++;
      end
      m_j++;
      if (!exp_acc) begin
        m_drn++;
        if (m_drn == nr - 1) begin
          m_active = 1'b0;
          done_pend = 1'b1;
          check("adv_total", 128'(dut_adv), 128'(m_k + nr - 1));
          check("acc_reset_cnt", 128'(dut_ar), 128'(1));
          check("sb_empty", 128'(act_q.size()), 128'(0));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) monitor_step();
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_vld"}, 128'(o_vld), 128'(0));
    check({tag, "_adv"}, 128'(o_rdy), 128'(0));
    check({tag, "_acc_reset"}, 128'(o_ar), 128'(0));
    check({tag, "_act_rdy"}, 128'(o_act_rdy), 128'(0));
    check({tag, "_busy"}, 128'(o_busy), 128'(0));
    check({tag, "_done"}, 128'(o_done), 128'(0));
    check({tag, "_act"}, o_act, 128'(0));
    check({tag, "_wgt"}, o_wgt, 128'(0));
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    mon_en = 1'b0;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 two-cycle stall, 2 wgt late by 5, 3 random, 4 reset in DRAIN
  task automatic run_tile(input bit s, input int k, input int mode, input int exp_lat);
    int lat;
    bit acc;
    model_clear();
    sel = s;
    lat = -1;
    act_data = rand128();
    wgt_data = rand128();
    act_vld = 1'b1;
    wgt_vld = 1'b1;
    bank_stall = 1'b0;
    start = 1'b1;
    cfg_k = CW'(k);
    @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    m_k = k;
    m_active = (k != 0);
    if (k == 0) done_pend = 1'b1;
    for (int c = 1; c <= 400 && lat < 0; c++) begin
      if (mode == 4 && m_active && m_acc == m_k && m_drn >= 2) begin
        mid_reset();
        return;
      end
      case (mode)
        1: bank_stall = (c == 2 || c == 3);
        2: wgt_vld = (c > 5);
        3: begin
          if (!act_vld) act_vld = ($urandom_range(3) != 0);
          if (!wgt_vld) wgt_vld = ($urandom_range(3) != 0);
          bank_stall = ($urandom_range(3) == 0);
          start = (c == 7);
          cfg_k = CW'(5);
        end
        default: ;
      endcase
      @(negedge clk);
      acc = o_act_rdy;
      if (o_done) lat = c;
      @(posedge clk);
      #1;
      if (acc) begin
        act_data = rand128();
        wgt_data = rand128();
        if (mode == 3) begin
          act_vld = ($urandom_range(3) != 0);
          wgt_vld = ($urandom_range(3) != 0);
        end
      end
    end
    start = 1'b0;
    if (exp_lat >= 0) check("done_latency", 128'(lat), 128'(exp_lat));
    else check("done_seen", 128'(lat > 0), 128'(1));
  endtask

  initial begin
    sel = 1'b0; start = 1'b0; cfg_k = '0; bank_stall = 1'b0;
    act_vld = 1'b0; wgt_vld = 1'b0; act_data = '0; wgt_data = '0;
    mon_en = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    #1 check_idle("reset4");
    sel = 1'b1;
    #1 check_idle("reset16");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run_tile(1'b0, 3, 0, 7);
    run_tile(1'b0, 3, 1, 9);
    run_tile(1'b0, 3, 2, 12);
    run_tile(1'b0, 0, 0, 1);
    run_tile(1'b0, 1, 0, 5);
    run_tile(1'b0, 9, 3, -1);
    run_tile(1'b1, 6, 4, -1);
    run_tile(1'b1, 4, 0, 20);
    run_tile(1'b1, 20, 3, -1);
    run_tile(1'b1, 0, 0, 1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
